cprod_accum: RTL and testbench
==============================

# cprod_accum

Complex product accumulator that sits directly downstream of the `cmult` complex multiplier. It sums a fixed number of consecutive full-precision complex products `pr`/`pi` into a widened accumulator, for correlators and dot-products. At the end of each block it rounds, scales and narrows the sum to the output width. It then emits one single-cycle result strobe per block.

## Interface

Parameters:
- `IWIDTH`, 35: input width per component; equals AWIDTH+BWIDTH+1 of the feeding multiplier.
- `OWIDTH`, 16: output width per component.
- `ACC_LEN`, 16: products per block; must be ≥2.
- `SHIFT`, 4: right-shift applied to the accumulated sum before narrowing; range 1..AW-1.
- AW (derived, not overridable): accumulator width, IWIDTH+$clog2(ACC_LEN).

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `in_re`/`in_im` hold a product this cycle. The caller delays its own valid by the multiplier's 6-cycle latency so it aligns with the product.
- `in_re`, in, IWIDTH signed: real product.
- `in_im`, in, IWIDTH signed: imaginary product.
- `flush`, in, 1: synchronous discard of the partial block.
- `out_valid`, out, 1: one-cycle result strobe.
- `out_re`, out, OWIDTH signed: scaled real sum.
- `out_im`, out, OWIDTH signed: scaled imaginary sum.
- `out_ovf`, out, 1: saturation occurred on either component of the current result.
- `busy`, out, 1: a partial block is in progress (count ≠ 0).

## Operation

- **Input stage, counter and state:**
  - `cnt` runs 0..ACC_LEN-1; `acc_re`/`acc_im` are AW bits wide and sign-extended.
  - IDLE (cnt=0) / ACCUM (cnt>0); `busy` = ACCUM.
  - When `in_valid` is high and cnt < ACC_LEN-1: acc += input, cnt++.
  - When `in_valid` is high and cnt = ACC_LEN-1: load `sum_reg` with acc+input, clear acc to 0, cnt to 0, and raise an internal `sum_vld` for one cycle.
  - When `in_valid` is low, acc and cnt hold. Gaps of any length are allowed.
- **`flush`:**
  - Clears acc and cnt to 0 and drops any `in_valid` sample in the same cycle; flush wins.
  - It does not cancel a `sum_vld` or result already in flight.
- **Round stage:** rnd = (sum_reg + 2^(SHIFT-1)) >>> SHIFT, computed at AW bits. This is round-half-up, so ties round toward +inf.
- **Narrow stage:** converts rnd to OWIDTH per the configuration below and registers `out_re`, `out_im`, `out_ovf` and `out_valid`.
- **Arithmetic and widths:**
  - The accumulator cannot overflow by construction, because AW includes $clog2(ACC_LEN) guard bits.
  - Overflow is only possible in the narrow stage.
- Outputs hold their last value while `out_valid` is low.

## Timing

- Edge E samples the last product of a block. `sum_reg` updates at E, the round register at E+1 and the output register at E+2.
- `out_valid` is high for exactly the one cycle following edge E+2. Fixed latency is 3 edges.
- Throughput is one product per cycle. Blocks can run back-to-back with no idle cycle, and then `out_valid` pulses every ACC_LEN cycles.
- Reset, asynchronous on `rst` high:
  - Cleared to 0: cnt, acc, `sum_reg`, the round register, all pipeline valids, `out_valid`, `out_re`, `out_im`, `out_ovf` and `busy`.
  - Reset mid-block discards the block, and in-flight results never appear.
  - The first block after reset release starts at cnt=0.

## Configuration

- `CPROD_ACCUM_SAT_EN` defined:
  - The narrow stage saturates: rnd > 2^(OWIDTH-1)-1 gives the maximum, and rnd < -2^(OWIDTH-1) gives the minimum.
  - `out_ovf` is 1 when either component saturated, and is registered with the result.
- Not defined:
  - The narrow stage takes the low OWIDTH bits of rnd (two's-complement wrap).
  - `out_ovf` is constant 0 and no saturation compare logic is built.

## Test plan

Use IWIDTH=35, OWIDTH=16, ACC_LEN=4, SHIFT=2.

- **Basic block:** 4 consecutive valids with re=1,2,3,4 and im=-1,-2,-3,-4 → one `out_valid` 3 edges after the 4th sample, `out_re`=3, `out_im`=-2, `out_ovf`=0.
- **Gapped input:** same samples with 1–5 idle cycles between them → identical result, one pulse only. `busy` is high from the 1st sample through the 4th.
- **Saturation:** 4 samples of re=2^20, im=-2^20. With `CPROD_ACCUM_SAT_EN`: `out_re`=32767, `out_im`=-32768, `out_ovf`=1. Without it: `out_re`=0, `out_im`=0, `out_ovf`=0.
- **Flush:** 2 samples of 100, then `flush` coincident with a 3rd sample of 100, then 4 samples of re=1, im=1 → single result `out_re`=`out_im`=1 ((4+2)>>2).
- **Back-to-back blocks:** 8 consecutive valids, values 1..8 on both components → pulses exactly 4 cycles apart; results 3 then 7, (10+2)>>2 and (26+2)>>2.
- **Reset mid-block:** assert `rst` asynchronously after 3 samples → all outputs 0 immediately. After release, 4 samples of 4 produce `out_re`=`out_im`=4 with no stale pulse.

Source files
------------

// File: rtl/cprod_accum.sv
// Complex product accumulator: sums ACC_LEN products, rounds, scales and narrows each block sum.
// Optional macro CPROD_ACCUM_SAT_EN selects saturating narrowing with overflow flag (default: wrap).
module cprod_accum #(
  parameter int IWIDTH  = 35,
  parameter int OWIDTH  = 16,
  parameter int ACC_LEN = 16,
  parameter int SHIFT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [IWIDTH-1:0] in_re,
  input  logic signed [IWIDTH-1:0] in_im,
  input  logic                     flush,
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] out_re,
  output logic signed [OWIDTH-1:0] out_im,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int CW = $clog2(ACC_LEN);
  localparam int AW = IWIDTH + CW;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (SHIFT - 1);

`ifdef CPROD_ACCUM_SAT_EN
  // Saturation needs the full-width rounded value to detect out-of-range sums.
  localparam int RW = AW;
  localparam logic signed [AW-1:0] MAXV = {{(AW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  function automatic logic [OWIDTH:0] narrow(input logic signed [RW-1:0] x);
    if (x > MAXV)      return {1'b1, 1'b0, {(OWIDTH-1){1'b1}}};
    else if (x < MINV) return {1'b1, 1'b1, {(OWIDTH-1){1'b0}}};
    else               return {1'b0, x[OWIDTH-1:0]};
  endfunction
`else
  // Wrapping keeps only the low OWIDTH bits, so the round register stores just those.
  localparam int RW = OWIDTH;

  function automatic logic [OWIDTH:0] narrow(input logic signed [RW-1:0] x);
    return {1'b0, x};
  endfunction
`endif

  function automatic logic signed [RW-1:0] round_shift(input logic signed [AW-1:0] x);
    return RW'((x + HALF) >>> SHIFT);
  endfunction

  logic [CW-1:0]          r_cnt;
  logic signed [AW-1:0]   r_acc_re, r_acc_im;
  logic signed [AW-1:0]   r_sum_re_p0, r_sum_im_p0;
  logic                   r_vld_p0;
  logic signed [RW-1:0]   r_rnd_re_p1, r_rnd_im_p1;
  logic                   r_vld_p1;
  logic signed [OWIDTH-1:0] r_out_re_p2, r_out_im_p2;
  logic                   r_ovf_p2, r_vld_p2;

  logic signed [AW-1:0]   w_acc_re_nxt, w_acc_im_nxt;
  logic [OWIDTH:0]        w_nar_re, w_nar_im;

  assign w_acc_re_nxt = r_acc_re + {{CW{in_re[IWIDTH-1]}}, in_re};
  assign w_acc_im_nxt = r_acc_im + {{CW{in_im[IWIDTH-1]}}, in_im};
  assign w_nar_re     = narrow(r_rnd_re_p1);
  assign w_nar_im     = narrow(r_rnd_im_p1);

  // Stage p0: accumulate; the last product of a block lands in the sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_sum_re_p0 <= '0;
      r_sum_im_p0 <= '0;
      r_vld_p0    <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      if (flush) begin
        r_cnt    <= '0;
        r_acc_re <= '0;
        r_acc_im <= '0;
      end else if (in_valid) begin
        if (r_cnt == LAST) begin
          r_sum_re_p0 <= w_acc_re_nxt;
          r_sum_im_p0 <= w_acc_im_nxt;
          r_acc_re    <= '0;
          r_acc_im    <= '0;
          r_cnt       <= '0;
          r_vld_p0    <= 1'b1;
        end else begin
          r_acc_re <= w_acc_re_nxt;
          r_acc_im <= w_acc_im_nxt;
          r_cnt    <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: round half up and scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd_re_p1 <= '0;
      r_rnd_im_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_rnd_re_p1 <= round_shift(r_sum_re_p0);
        r_rnd_im_p1 <= round_shift(r_sum_im_p0);
      end
    end
  end

  // Stage p2: narrow to the output width; results hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_re_p2 <= '0;
      r_out_im_p2 <= '0;
      r_ovf_p2    <= 1'b0;
      r_vld_p2    <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_re_p2 <= w_nar_re[OWIDTH-1:0];
        r_out_im_p2 <= w_nar_im[OWIDTH-1:0];
        r_ovf_p2    <= w_nar_re[OWIDTH] | w_nar_im[OWIDTH];
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_re    = r_out_re_p2;
  assign out_im    = r_out_im_p2;
  assign out_ovf   = r_ovf_p2;
  assign busy      = (r_cnt != '0);

endmodule

// File: tb/tb_cprod_accum.sv
// Scoreboard bench for cprod_accum (IWIDTH=35, OWIDTH=16, ACC_LEN=4, SHIFT=2).
module tb_cprod_accum;
  localparam int IW = 35;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, flush;
  logic signed [IW-1:0] in_re, in_im;
  logic                 out_valid, out_ovf, busy;
  logic signed [OW-1:0] out_re, out_im;

  cprod_accum #(.IWIDTH(IW), .OWIDTH(OW), .ACC_LEN(4), .SHIFT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .flush(flush), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    logic   ovf;
    int     cyc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  exp_t e_end;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input longint re, input longint im, input logic v, input logic fl);
    @(negedge clk);
    in_valid = v;
    flush    = fl;
    in_re    = re[IW-1:0];
    in_im    = im[IW-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0);
  endtask

  // Called right after driving the last sample of a block: result due 3 edges later.
  task automatic push(input longint re, input longint im, input logic ovf);
    exp_t e;
    e.re  = re;
    e.im  = im;
    e.ovf = ovf;
    e.cyc = cyc + 3;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got out_valid=1 re=%0d im=%0d expected no pulse", out_re, out_im);
      end else begin
        e_mon = q.pop_front();
        chk("out_re", longint'(out_re), e_mon.re);
        chk("out_im", longint'(out_im), e_mon.im);
        chk("out_ovf", longint'(out_ovf), longint'(e_mon.ovf));
        chk("pulse_cycle", longint'(cyc), longint'(e_mon.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_re = '0; in_im = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_re", longint'(out_re), 0);
    chk("rst_out_im", longint'(out_im), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    chk("rst_busy", longint'(busy), 0);
    rst = 1'b0;

    // basic block: sums 10 / -10 -> 3 / -2
    for (int i = 1; i <= 4; i++) drive(i, -i, 1'b1, 1'b0);
    push(3, -2, 1'b0);
    idle(6);

    // gapped block, busy high from first sample through the last
    for (int i = 1; i <= 4; i++) begin
      drive(i, -i, 1'b1, 1'b0);
      if (i == 4) push(3, -2, 1'b0);
      for (int g = 0; g < ((i == 4) ? 5 : i + 1); g++) begin
        drive(0, 0, 1'b0, 1'b0);
        chk("gap_busy", longint'(busy), (i < 4) ? 1 : 0);
      end
    end

    // saturation / wrap: sums +/-2^22 -> rnd +/-2^20
    for (int i = 0; i < 4; i++) drive(64'sd1048576, -64'sd1048576, 1'b1, 1'b0);
`ifdef CPROD_ACCUM_SAT_EN
    push(32767, -32768, 1'b1);
`else
    push(0, 0, 1'b0);
`endif
    idle(5);

    // flush discards the partial block and its coincident sample
    drive(100, 100, 1'b1, 1'b0);
    drive(100, 100, 1'b1, 1'b0);
    drive(100, 100, 1'b1, 1'b1);
    drive(1, 1, 1'b1, 1'b0);
    chk("flush_busy", longint'(busy), 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 1'b1, 1'b0);
    push(1, 1, 1'b0);
    idle(5);

    // back-to-back blocks: sums 10 and 26 -> 3 and 7, 4 cycles apart
    for (int i = 1; i <= 8; i++) begin
      drive(i, i, 1'b1, 1'b0);
      if (i == 4) push(3, 3, 1'b0);
      if (i == 8) push(7, 7, 1'b0);
    end
    idle(6);

    // asynchronous reset in the middle of a block
    for (int i = 0; i < 3; i++) drive(4, 4, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk("pre_rst_busy", longint'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", longint'(out_valid), 0);
    chk("arst_out_re", longint'(out_re), 0);
    chk("arst_out_im", longint'(out_im), 0);
    chk("arst_out_ovf", longint'(out_ovf), 0);
    chk("arst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(4, 4, 1'b1, 1'b0);
    push(4, 4, 1'b0);
    idle(6);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    while (q.size() > 0) begin
      e_end = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: got no out_valid expected re=%0d im=%0d at cycle %0d", e_end.re, e_end.im, e_end.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
